// File: rtl/cpu_instruction_queue.sv
// cpu_instruction_queue
//
// Decoupling queue between instruction fetch and decode. Buffers up to DEPTH
// (address, instruction) pairs in program order and hands the oldest to decode
// over a valid/ready handshake. Unconditional J/JAL enqueued in normal flow
// redirect fetch early; execute-stage redirects take priority, flush the
// wrong-path entries and preserve the branch delay slot.
//
// Ports:
//   clock, reset                  clock and synchronous active-high reset
//   fetch_address/instruction     pair presented by fetch
//   fetch_valid                   presented pair is valid
//   fetch_full                    registered backpressure to fetch
//   branch_address/inst_addr      redirect target and causing instruction address
//   branch_valid                  one-cycle redirect pulse to fetch
//   dec_address/instruction       head entry presented to decode
//   dec_valid, dec_ready          decode handshake
//   ex_redirect_valid/target/     execute-stage taken branch or JR
//   ex_redirect_inst_addr
module cpu_instruction_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fetch_address,
    input  logic [31:0] fetch_instruction,
    input  logic        fetch_valid,
    output logic        fetch_full,
    output logic [31:0] branch_address,
    output logic [31:0] branch_inst_addr,
    output logic        branch_valid,
    output logic [31:0] dec_address,
    output logic [31:0] dec_instruction,
    output logic        dec_valid,
    input  logic        dec_ready,
    input  logic        ex_redirect_valid,
    input  logic [31:0] ex_redirect_target,
    input  logic [31:0] ex_redirect_inst_addr
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

    typedef enum logic [1:0] {StRun, StWaitSlot, StWaitTarget} state_e;

    state_e          state_q, state_d;
    logic [31:0]     slot_q, slot_d;
    logic [31:0]     target_q, target_d;
    logic [31:0]     addr_mem_q [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            fetch_full_q;
    logic [31:0]     last_disp_q, last_disp_d;
    logic            branch_valid_q, branch_valid_d;
    logic [31:0]     branch_address_q, branch_address_d;
    logic [31:0]     branch_inst_addr_q, branch_inst_addr_d;

    logic            candidate;
    logic            enq;
    logic            pop;
    logic            is_jump;
    logic [31:0]     fetch_next;
    logic [31:0]     jump_target;
    logic [31:0]     ex_slot;
    logic            slot_found;
    logic [PtrW-1:0] slot_wr;
    logic [CntW-1:0] slot_keep;

    assign candidate   = fetch_valid & ~fetch_full_q;
    assign fetch_next  = fetch_address + 32'd4;
    // J (opcode 2) and JAL (opcode 3) differ only in the lowest opcode bit.
    assign is_jump     = fetch_instruction[31:27] == 5'b00001;
    assign jump_target = {fetch_next[31:28], fetch_instruction[25:0], 2'b00};
    assign ex_slot     = ex_redirect_inst_addr + 32'd4;

    assign dec_valid       = (count_q != '0) & ~ex_redirect_valid;
    assign pop             = dec_valid & dec_ready;
    assign dec_address     = (count_q != '0) ? addr_mem_q[rd_ptr_q] : '0;
    assign dec_instruction = (count_q != '0) ? inst_mem_q[rd_ptr_q] : '0;

    assign fetch_full       = fetch_full_q;
    assign branch_valid     = branch_valid_q;
    assign branch_address   = branch_address_q;
    assign branch_inst_addr = branch_inst_addr_q;

    // Locate the oldest queued delay slot of an execute redirect; everything
    // up to and including it is on the correct path.
    always_comb begin
        slot_found = 1'b0;
        slot_wr    = '0;
        slot_keep  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!slot_found && (CntW'(i) < count_q) &&
                (addr_mem_q[rd_ptr_q + PtrW'(i)] == ex_slot)) begin
                slot_found = 1'b1;
                slot_wr    = rd_ptr_q + PtrW'(i + 1);
                slot_keep  = CntW'(i + 1);
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        slot_d             = slot_q;
        target_d           = target_q;
        rd_ptr_d           = rd_ptr_q;
        wr_ptr_d           = wr_ptr_q;
        count_d            = count_q;
        last_disp_d        = last_disp_q;
        branch_valid_d     = 1'b0;
        branch_address_d   = branch_address_q;
        branch_inst_addr_d = branch_inst_addr_q;
        enq                = 1'b0;

        if (ex_redirect_valid) begin
            // Execute redirect wins: no enqueue, no pop, no early-jump pulse.
            branch_valid_d     = 1'b1;
            branch_address_d   = ex_redirect_target;
            branch_inst_addr_d = ex_redirect_inst_addr;
            slot_d             = ex_slot;
            target_d           = ex_redirect_target;
            if (last_disp_q == ex_slot) begin
                wr_ptr_d = rd_ptr_q;
                count_d  = '0;
                state_d  = StWaitTarget;
            end else if (slot_found) begin
                wr_ptr_d = slot_wr;
                count_d  = slot_keep;
                state_d  = StWaitTarget;
            end else begin
                wr_ptr_d = rd_ptr_q;
                count_d  = '0;
                state_d  = StWaitSlot;
            end
        end else begin
            unique case (state_q)
                StRun:        enq = candidate;
                StWaitSlot:   enq = candidate & (fetch_address == slot_q);
                StWaitTarget: enq = candidate & (fetch_address == target_q);
                default:      enq = 1'b0;
            endcase

            if (enq) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                unique case (state_q)
                    StRun: begin
                        if (is_jump) begin
                            branch_valid_d     = 1'b1;
                            branch_address_d   = jump_target;
                            branch_inst_addr_d = fetch_address;
                            slot_d             = fetch_next;
                            target_d           = jump_target;
                            state_d            = StWaitSlot;
                        end
                    end
                    StWaitSlot:   state_d = StWaitTarget;
                    StWaitTarget: state_d = StRun;
                    default:      state_d = StRun;
                endcase
            end

            if (pop) begin
                rd_ptr_d    = rd_ptr_q + PtrW'(1);
                last_disp_d = addr_mem_q[rd_ptr_q];
            end

            count_d = count_q + CntW'(enq) - CntW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= StRun;
            slot_q             <= '0;
            target_q           <= '0;
            rd_ptr_q           <= '0;
            wr_ptr_q           <= '0;
            count_q            <= '0;
            fetch_full_q       <= 1'b0;
            last_disp_q        <= '0;
            branch_valid_q     <= 1'b0;
            branch_address_q   <= '0;
            branch_inst_addr_q <= '0;
        end else begin
            state_q            <= state_d;
            slot_q             <= slot_d;
            target_q           <= target_d;
            rd_ptr_q           <= rd_ptr_d;
            wr_ptr_q           <= wr_ptr_d;
            count_q            <= count_d;
            fetch_full_q       <= (count_d == DepthCnt);
            last_disp_q        <= last_disp_d;
            branch_valid_q     <= branch_valid_d;
            branch_address_q   <= branch_address_d;
            branch_inst_addr_q <= branch_inst_addr_d;
        end
    end

    // Storage needs no reset: the read side is gated by count.
    always_ff @(posedge clock) begin
        if (enq) begin
            addr_mem_q[wr_ptr_q] <= fetch_address;
            inst_mem_q[wr_ptr_q] <= fetch_instruction;
        end
    end

endmodule

// File: tb/tb_cpu_instruction_queue.sv
module tb_cpu_instruction_queue;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fetch_address = '0;
    logic [31:0] fetch_instruction = '0;
    logic        fetch_valid = 1'b0;
    logic        fetch_full;
    logic [31:0] branch_address;
    logic [31:0] branch_inst_addr;
    logic        branch_valid;
    logic [31:0] dec_address;
    logic [31:0] dec_instruction;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic        ex_redirect_valid = 1'b0;
    logic [31:0] ex_redirect_target = '0;
    logic [31:0] ex_redirect_inst_addr = '0;

    cpu_instruction_queue #(.DEPTH(DEPTH)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .fetch_address         (fetch_address),
        .fetch_instruction     (fetch_instruction),
        .fetch_valid           (fetch_valid),
        .fetch_full            (fetch_full),
        .branch_address        (branch_address),
        .branch_inst_addr      (branch_inst_addr),
        .branch_valid          (branch_valid),
        .dec_address           (dec_address),
        .dec_instruction       (dec_instruction),
        .dec_valid             (dec_valid),
        .dec_ready             (dec_ready),
        .ex_redirect_valid     (ex_redirect_valid),
        .ex_redirect_target    (ex_redirect_target),
        .ex_redirect_inst_addr (ex_redirect_inst_addr)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: program-ordered queue plus the filter rules.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] i;
    } ent_t;

    ent_t        mq[$];
    int          mstate = 0;  // 0 run, 1 waiting for slot, 2 waiting for target
    logic [31:0] ms = '0, mt = '0, mlast = '0, mba = '0, mbi = '0;
    bit          mfull = 1'b0, mbv = 1'b0;

    always @(posedge clock) begin : model
        bit          cand, take, mpop;
        int          k;
        logic [31:0] s, n;
        ent_t        e;
        if (reset) begin
            mq.delete();
            mstate = 0; ms = '0; mt = '0; mlast = '0;
            mfull = 1'b0; mbv = 1'b0; mba = '0; mbi = '0;
        end else begin
            cand = fetch_valid && !mfull;
            mpop = (mq.size() != 0) && !ex_redirect_valid && dec_ready;
            mbv  = 1'b0;
            if (ex_redirect_valid) begin
                s = ex_redirect_inst_addr + 32'd4;
                mbv = 1'b1; mba = ex_redirect_target; mbi = ex_redirect_inst_addr;
                ms = s; mt = ex_redirect_target;
                k = -1;
                for (int j = 0; j < mq.size(); j++)
                    if (k < 0 && mq[j].a == s) k = j;
                if (mlast == s) begin
                    mq.delete(); mstate = 2;
                end else if (k >= 0) begin
                    mq = mq[0:k]; mstate = 2;
                end else begin
                    mq.delete(); mstate = 1;
                end
            end else begin
                if (mpop) begin
                    mlast = mq[0].a;
                    void'(mq.pop_front());
                end
                if (cand) begin
                    e.a = fetch_address; e.i = fetch_instruction;
                    take = (mstate == 0) || (mstate == 1 && e.a == ms) ||
                           (mstate == 2 && e.a == mt);
                    if (take) begin
                        mq.push_back(e);
                        if (mstate == 0 && (e.i[31:26] == 6'd2 || e.i[31:26] == 6'd3)) begin
                            n = e.a + 32'd4;
                            mba = {n[31:28], e.i[25:0], 2'b00};
                            mbi = e.a; mbv = 1'b1;
                            ms = n; mt = mba; mstate = 1;
                        end else if (mstate == 1) begin
                            mstate = 2;
                        end else if (mstate == 2) begin
                            mstate = 0;
                        end
                    end
                end
            end
            mfull = (mq.size() == DEPTH);
        end
    end

    logic [31:0] dut_log[$];
    logic [31:0] exp_q[$];

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin : compare
        bit ev;
        ev = (mq.size() != 0) && !ex_redirect_valid;
        chk("dec_valid", {31'b0, dec_valid}, {31'b0, ev});
        if (ev) begin
            chk("dec_address", dec_address, mq[0].a);
            chk("dec_instruction", dec_instruction, mq[0].i);
        end
        chk("fetch_full", {31'b0, fetch_full}, {31'b0, mfull});
        chk("branch_valid", {31'b0, branch_valid}, {31'b0, mbv});
        if (mbv) begin
            chk("branch_address", branch_address, mba);
            chk("branch_inst_addr", branch_inst_addr, mbi);
        end
        if (dec_valid === 1'b1 && dec_ready === 1'b1) dut_log.push_back(dec_address);
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Present a pair and hold it until the queue accepts (enqueues or drops) it.
    task automatic fetch(input logic [31:0] a, input logic [31:0] i);
        bit was_full;
        int n;
        n = 0;
        fetch_address = a; fetch_instruction = i; fetch_valid = 1'b1;
        do begin
            was_full = mfull;
            tick();
            n++;
        end while (was_full && n < 50);
        if (was_full) begin
            tests++; fails++;
            $display("FAIL fetch_timeout: addr %h still not accepted after %0d cycles", a, n);
        end
        fetch_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; dec_ready = 1'b0; fetch_valid = 1'b0; ex_redirect_valid = 1'b0;
        tick();
        reset = 1'b0;
        dut_log.delete();
    endtask

    task automatic chk_log(input string name);
        chk({name, "_count"}, 32'(dut_log.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < dut_log.size(); j++)
            chk(name, dut_log[j], exp_q[j]);
    endtask

    task automatic ex_pulse(input logic [31:0] inst, input logic [31:0] tgt);
        ex_redirect_valid = 1'b1; ex_redirect_inst_addr = inst; ex_redirect_target = tgt;
        tick();
        ex_redirect_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        chk("reset_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("reset_fetch_full", {31'b0, fetch_full}, 32'd0);
        chk("reset_branch_valid", {31'b0, branch_valid}, 32'd0);
        chk("reset_dec_address", dec_address, 32'd0);
        chk("reset_dec_instruction", dec_instruction, 32'd0);
        chk("reset_branch_address", branch_address, 32'd0);
        chk("reset_branch_inst_addr", branch_inst_addr, 32'd0);
        reset = 1'b0;

        // Streaming with decode always ready.
        do_reset();
        dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) fetch(32'hbfc00000 + 32'(4 * i), 32'h20000000 + 32'(i));
        repeat (3) tick();
        exp_q = {32'hbfc00000, 32'hbfc00004, 32'hbfc00008, 32'hbfc0000c,
                 32'hbfc00010, 32'hbfc00014, 32'hbfc00018, 32'hbfc0001c};
        chk_log("stream");

        // Backpressure: fill with decode stalled, then release.
        do_reset();
        for (int i = 0; i < 4; i++) fetch(32'h00001000 + 32'(4 * i), 32'h24000000 + 32'(i));
        chk("bp_full_after_4", {31'b0, fetch_full}, 32'd1);
        dec_ready = 1'b1;
        fetch(32'h00001010, 32'h24000004);
        fetch(32'h00001014, 32'h24000005);
        repeat (6) tick();
        exp_q = {32'h00001000, 32'h00001004, 32'h00001008, 32'h0000100c,
                 32'h00001010, 32'h00001014};
        chk_log("backpressure");

        // Early jump redirect and slot/target filtering.
        do_reset();
        dec_ready = 1'b1;
        fetch(32'hbfc00000, 32'h08000010);
        chk("ej_branch_valid", {31'b0, branch_valid}, 32'd1);
        chk("ej_branch_address", branch_address, 32'hb0000040);
        chk("ej_branch_inst_addr", branch_inst_addr, 32'hbfc00000);
        fetch(32'hbfc00004, 32'h00000000);
        chk("ej_pulse_ends", {31'b0, branch_valid}, 32'd0);
        fetch(32'hbfc00008, 32'h00000000);
        fetch(32'hb0000040, 32'h00000000);
        repeat (3) tick();
        exp_q = {32'hbfc00000, 32'hbfc00004, 32'hb0000040};
        chk_log("early_jump");

        // Execute redirect with its delay slot still queued.
        do_reset();
        fetch(32'h100, 32'h0); fetch(32'h104, 32'h0); fetch(32'h108, 32'h0);
        fetch_valid = 1'b1; fetch_address = 32'h10c;
        ex_pulse(32'h100, 32'h200);
        fetch_valid = 1'b0;
        chk("exq_branch_valid", {31'b0, branch_valid}, 32'd1);
        chk("exq_branch_address", branch_address, 32'h200);
        chk("exq_branch_inst_addr", branch_inst_addr, 32'h100);
        fetch(32'h10c, 32'h0); fetch(32'h104, 32'h0); fetch(32'h200, 32'h0);
        dec_ready = 1'b1;
        repeat (6) tick();
        exp_q = {32'h100, 32'h104, 32'h200};
        chk_log("ex_slot_queued");

        // Execute redirect with its delay slot already dispatched.
        do_reset();
        dec_ready = 1'b1;
        fetch(32'h100, 32'h0); fetch(32'h104, 32'h0);
        repeat (2) tick();
        dec_ready = 1'b0;
        fetch(32'h108, 32'h0);
        ex_pulse(32'h100, 32'h300);
        chk("exd_queue_empty", {31'b0, dec_valid}, 32'd0);
        fetch(32'h104, 32'h0); fetch(32'h300, 32'h0);
        dec_ready = 1'b1;
        repeat (4) tick();
        exp_q = {32'h100, 32'h104, 32'h300};
        chk_log("ex_slot_dispatched");

        // Execute redirect on the same edge a jump would be enqueued.
        do_reset();
        dec_ready = 1'b1;
        fetch_valid = 1'b1; fetch_address = 32'hbfc00000; fetch_instruction = 32'h08000010;
        ex_pulse(32'h500, 32'h400);
        fetch_valid = 1'b0;
        chk("sim_branch_address", branch_address, 32'h400);
        chk("sim_branch_inst_addr", branch_inst_addr, 32'h500);
        // Back-to-back redirects: the second replaces slot and target.
        ex_pulse(32'h100, 32'h200);
        ex_pulse(32'h600, 32'h700);
        chk("b2b_branch_address", branch_address, 32'h700);
        fetch(32'h200, 32'h0); fetch(32'h604, 32'h0); fetch(32'h700, 32'h0);
        repeat (3) tick();
        exp_q = {32'h604, 32'h700};
        chk_log("back_to_back");

        // Reset with entries queued and a jump arriving on the same edge.
        do_reset();
        fetch(32'h100, 32'h0); fetch(32'h104, 32'h0); fetch(32'h108, 32'h0);
        fetch_valid = 1'b1; fetch_address = 32'h10c; fetch_instruction = 32'h08000010;
        reset = 1'b1;
        tick();
        reset = 1'b0; fetch_valid = 1'b0;
        chk("rst_dec_valid", {31'b0, dec_valid}, 32'd0);
        chk("rst_fetch_full", {31'b0, fetch_full}, 32'd0);
        chk("rst_branch_valid", {31'b0, branch_valid}, 32'd0);
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
